i2c_target_regs: RTL and testbench
==================================

// Module: i2c_target_regs
// PURPOSE
//   I2C target (slave) responder with byte-register access; other end of the MuraxArduino I2C master.
//   Lets a second board or the bench drive the Murax I2C pins against known registers.
//   Sits between SB_IO open-drain SDA/SCL pins and a user register bank. Supports write (pointer + data) and read, with repeated START.
// PARAMETERS
//   DEV_ADDR  7'h42  7-bit target address matched after START
//   AW        8      register pointer width; pointer wraps modulo 2^AW
// PORTS
//   CLK        in   1   system clock; must be >= 16x SCL frequency
//   reset_in   in   1   asynchronous, active-high reset
//   scl_i      in   1   SCL pin level (input only; no clock stretching)
//   sda_i      in   1   SDA pin level
//   sda_oe     out  1   1 = pull SDA low (connect to SB_IO OUTPUT_ENABLE, D_OUT_0=0)
//   reg_addr   out  AW  current register pointer
//   reg_wdata  out  8   received data byte, valid while reg_we=1
//   reg_we     out  1   one-CLK write strobe
//   reg_rd     out  1   one-CLK read request; reg_rdata sampled next CLK
//   reg_rdata  in   8   read data for reg_addr, registered source allowed
//   busy       out  1   1 from address match until STOP/restart-mismatch
// BEHAVIOUR
//   Reset: sda_oe=0, reg_we=0, reg_rd=0, busy=0, reg_addr=0, reg_wdata=0, state IDLE; SCL/SDA syncs preset to 1.
//   Input path: 2-FF synchronizer per line; edges detected on synced values (latency 3 CLK pin->edge).
//   START = sda fall while scl high; STOP = sda rise while scl high. Both override every state.
//   Bits sampled on scl rise, MSB first; SDA driven/changed only 1 CLK after scl fall.
//   States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
//   IDLE -START-> ADDR. ADDR: shift 8 bits; at 8th scl fall: match -> ADDR_ACK (sda_oe=1, busy=1), else IGNORE.
//   ADDR_ACK ends at next scl fall: R/W=0 -> PTR; R/W=1 -> RDATA (load byte, see below).
//   PTR: 8 bits -> PTR_ACK (sda_oe=1); reg_addr <= byte[AW-1:0]; then WDATA.
//   WDATA: 8 bits; at 8th scl fall: reg_wdata=byte, reg_we=1 one CLK with reg_addr unchanged, ACK driven,
//     reg_addr increments the CLK after reg_we. WDATA_ACK -> WDATA.
//   RDATA load: at scl fall, reg_rd=1 (reg_addr=pointer); next CLK shift <= reg_rdata, pointer++;
//     next CLK sda_oe = ~shift[7]. Subsequent bits: sda_oe = ~bit after each scl fall.
//   RACK: after 8th bit sda_oe=0; sample master ACK at scl rise: ACK(0) -> RDATA reload; NACK(1) -> IGNORE.
//   IGNORE: sda_oe=0, no strobes, waits for START (-> ADDR) or STOP (-> IDLE).
//   Repeated START: any state -> ADDR, sda_oe=0, pointer retained (enables write-ptr/restart/read).
//   STOP: any state -> IDLE, sda_oe=0 and busy=0 within 1 CLK of detection; partial byte discarded, no reg_we.
//   Pointer-only write (START,addr,ptr,STOP): sets pointer, no reg_we.
//   Pointer wrap: 2^AW-1 -> 0 on increment, read or write.
//   General call (0x00) not matched. reset_in mid-transfer: sda_oe=0 asynchronously, state IDLE.
// CONFIGURATION
//   I2C_TARGET_FILTER_EN defined: 3-sample majority filter after synchronizers on SCL and SDA;
//     pulses <=1 CLK rejected; pin->edge latency 5 CLK; filter state resets to 1.
//   Not defined: no filter, latency 3 CLK, any 2-CLK-stable pulse is an edge.
// TESTING
//   Write: START,0x84,0x10,0xA5,0x5A,STOP -> 4 ACKs; reg_we @0x10 data 0xA5, @0x11 data 0x5A; final reg_addr 0x12.
//   Read: START,0x84,0x10,rSTART,0x85, read 2 (ACK,NACK), STOP; reg_rdata=~addr -> SDA bytes 0xEF,0xEE; reg_rd twice.
//   Mismatch: START,0x86,0x10,0x33,STOP -> sda_oe never 1, no reg_we/reg_rd, busy stays 0.
//   Abort: START,0x84,0x20, 4 bits of data, STOP -> no reg_we, state IDLE, sda_oe=0, reg_addr 0x20.
//   Wrap: ptr 0xFF, write 0x01,0x02 -> reg_we @0xFF then @0x00.
//   Reset during ADDR_ACK (sda_oe=1) -> sda_oe=0 same cycle; 1-CLK SCL glitch: ignored with FILTER_EN, bit miscount without.

Source files
------------

// File: rtl/i2c_target_regs_if.sv
// ----------------------------------------------------------------------------
// i2c_target_regs_if
//   Bundles the I2C pin signals and the register-bank handshake of the
//   i2c_target_regs responder.
//
//   Pins:      scl_i, sda_i   pin levels seen by the target
//              sda_oe         1 = target pulls SDA low
//   Registers: reg_addr       current register pointer (AW bits)
//              reg_wdata      received byte, valid while reg_we=1
//              reg_we         one-CLK write strobe
//              reg_rd         one-CLK read request
//              reg_rdata      read data for reg_addr, sampled the CLK after reg_rd
//              busy           target addressed and transfer in progress
//
//   Modports: slave = the target (i2c_target_regs); master = bus/bank side.
// ----------------------------------------------------------------------------
interface i2c_target_regs_if #(
  parameter int unsigned AW = 8
);
  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_rd;
  logic [7:0]    reg_rdata;
  logic          busy;

  modport slave (
    input  scl_i, sda_i, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy
  );

  modport master (
    output scl_i, sda_i, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, reg_rd, busy
  );
endinterface

// File: rtl/i2c_target_regs.sv
// ----------------------------------------------------------------------------
// i2c_target_regs
//   I2C target responder giving byte access to a user register bank.
//   Write: START, addr+W, pointer, data... STOP (pointer auto-increments).
//   Read:  START, addr+W, pointer, repeated START, addr+R, data... STOP.
//   No clock stretching; CLK must run at >= 16x the SCL frequency.
//
//   Ports:
//     CLK        system clock
//     reset_in   asynchronous, active-high reset
//     bus        i2c_target_regs_if.slave (pins + register handshake)
//
//   Parameters:
//     DEV_ADDR   7-bit target address (general call 0x00 is never matched)
//     AW         register pointer width (<= 8), wraps modulo 2^AW
//
//   Configuration macro:
//     I2C_TARGET_FILTER_EN  adds a 3-sample majority filter after the
//                           synchronizers; rejects pulses <= 1 CLK.
// ----------------------------------------------------------------------------
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h42,
  parameter int unsigned AW       = 8
) (
  input logic              CLK,
  input logic              reset_in,
  i2c_target_regs_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  // --------------------------------------------------------------------------
  // Input conditioning: 2-FF synchronizers, optional majority filter, edges
  // --------------------------------------------------------------------------
  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f;   // conditioned line levels
  logic       scl_d, sda_d;   // previous conditioned levels

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would chain the synchronizer stages.
  // Sync stages preset to 1 (idle bus level) so reset never fakes an edge.
  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_i};
      sda_sync <= {sda_sync[0], bus.sda_i};
      scl_d    <= scl_f;
      sda_d    <= sda_f;
    end
  end

`ifdef I2C_TARGET_FILTER_EN
  logic [2:0] scl_hist, sda_hist;
  logic       scl_flt, sda_flt;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // A single-CLK pulse occupies only one of three samples and is outvoted.
  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
      scl_flt  <= 1'b1;
      sda_flt  <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
      scl_flt  <= maj3(scl_hist);
      sda_flt  <= maj3(sda_hist);
    end
  end

  assign scl_f = scl_flt;
  assign sda_f = sda_flt;
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_f & ~scl_d;
  assign scl_fall  = ~scl_f &  scl_d;
  assign start_det =  scl_f &  scl_d &  sda_d & ~sda_f;
  assign stop_det  =  scl_f &  scl_d & ~sda_d &  sda_f;

  // --------------------------------------------------------------------------
  // Protocol FSM and datapath: one register process, one next-value process
  // --------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d, rd_q, rd_d;
  logic          load_q, load_d;     // shift just reloaded; drive its MSB next
  logic          oe_q, oe_d, busy_q, busy_d, rw_q, rw_d;

  always_ff @(posedge CLK or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rd_q      <= 1'b0;
      load_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      load_q    <= load_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch; a path that left
    // one unassigned would infer a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    rd_d      = 1'b0;
    load_d    = 1'b0;
    oe_d      = oe_q;
    busy_d    = busy_q;
    rw_d      = rw_q;

    // Follow-ups of strobes issued last CLK: the pointer moves only after the
    // bank has seen it, and read data is captured one CLK after reg_rd.
    if (we_q) ptr_d = ptr_q + AW'(1);
    if (rd_q) begin
      shift_d = bus.reg_rdata;
      ptr_d   = ptr_q + AW'(1);
      load_d  = 1'b1;
    end
    if (load_q) oe_d = ~shift_q[7];

    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      load_d  = 1'b0;
    end else if (start_det) begin
      // Repeated START keeps the pointer so write-ptr/restart/read works.
      state_d   = ADDR;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      load_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_f};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            oe_d      = 1'b1;
            if (state_q == ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
                rw_d    = shift_q[0];
              end else begin
                state_d = IGNORE;
                oe_d    = 1'b0;
                busy_d  = 1'b0;
              end
            end else if (state_q == PTR) begin
              state_d = PTR_ACK;
              ptr_d   = shift_q[AW-1:0];
            end else begin
              state_d = WDATA_ACK;
              wdata_d = shift_q;
              we_d    = 1'b1;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            oe_d      = 1'b0;
            bit_cnt_d = '0;
            if (state_q == ADDR_ACK && rw_q) begin
              state_d = RDATA;
              rd_d    = 1'b1;
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_d = RACK;
              oe_d    = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        RACK: begin
          // bit_cnt reaches 9 only on a master ACK; reload at the next fall.
          if (scl_rise) begin
            if (sda_f) state_d = IGNORE;
            else       bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            state_d   = RDATA;
            bit_cnt_d = '0;
            rd_d      = 1'b1;
          end
        end
        default: ;  // IDLE, IGNORE: wait for START/STOP
      endcase
    end
  end

  assign bus.sda_oe    = oe_q;
  assign bus.reg_addr  = ptr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_rd    = rd_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// ----------------------------------------------------------------------------
// tb_i2c_target_regs
//   Directed bench for i2c_target_regs: a bit-banged I2C master drives the
//   pins (SDA is wired-AND with the target's pull-down), the register bank
//   returns reg_rdata = ~reg_addr, and a negedge monitor logs strobes.
//   Honours I2C_TARGET_FILTER_EN for the SCL glitch scenario.
// ----------------------------------------------------------------------------
module tb_i2c_target_regs;
  localparam int Q = 8;  // CLKs per quarter SCL period (SCL = CLK/32)

  logic clk      = 1'b0;
  logic reset_in = 1'b1;
  logic scl_m    = 1'b1;
  logic sda_m    = 1'b1;

  int tests_run = 0;
  int fails     = 0;

  int         we_cnt    = 0;
  int         rd_cnt    = 0;
  logic       oe_seen   = 1'b0;
  logic       busy_seen = 1'b0;
  logic [7:0] we_addr [0:7];
  logic [7:0] we_data [0:7];

  i2c_target_regs_if #(.AW(8)) bus ();

  assign bus.scl_i     = scl_m;
  assign bus.sda_i     = sda_m & ~bus.sda_oe;
  assign bus.reg_rdata = ~bus.reg_addr;

  i2c_target_regs #(.DEV_ADDR(7'h42), .AW(8)) dut (
    .CLK      (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.reg_we) begin
      if (we_cnt < 8) begin
        we_addr[we_cnt] = bus.reg_addr;
        we_data[we_cnt] = bus.reg_wdata;
      end
      we_cnt++;
    end
    if (bus.reg_rd) rd_cnt++;
    if (bus.sda_oe) oe_seen = 1'b1;
    if (bus.busy)   busy_seen = 1'b1;
  end

  // ---------------------------------------------------------------- master
  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clear_mon();
    we_cnt = 0; rd_cnt = 0; oe_seen = 1'b0; busy_seen = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b0; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    scl_m = 1'b1; qwait();
    sda_m = 1'b1; qwait();
    qwait();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    qwait();
    scl_m = 1'b1; qwait(); qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; qwait();
    scl_m = 1'b1; qwait();
    ack = bus.sda_i; qwait();
    scl_m = 1'b0; qwait();
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; qwait();
      scl_m = 1'b1; qwait();
      b[i] = bus.sda_i; qwait();
      scl_m = 1'b0; qwait();
    end
    send_bit(ack);
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    tests_run++; if (bus.sda_oe !== 1'b0)     begin fails++; $display("FAIL reset_sda_oe got %b exp 0", bus.sda_oe); end
    tests_run++; if (bus.reg_we !== 1'b0)     begin fails++; $display("FAIL reset_reg_we got %b exp 0", bus.reg_we); end
    tests_run++; if (bus.reg_rd !== 1'b0)     begin fails++; $display("FAIL reset_reg_rd got %b exp 0", bus.reg_rd); end
    tests_run++; if (bus.busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    tests_run++; if (bus.reg_addr !== 8'h00)  begin fails++; $display("FAIL reset_reg_addr got %h exp 00", bus.reg_addr); end
    tests_run++; if (bus.reg_wdata !== 8'h00) begin fails++; $display("FAIL reset_reg_wdata got %h exp 00", bus.reg_wdata); end
  endtask

  task automatic test_write();
    logic [3:0] acks;
    clear_mon();
    i2c_start();
    write_byte(8'h84, acks[0]);
    tests_run++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL wr_busy_after_match got %b exp 1", bus.busy); end
    write_byte(8'h10, acks[1]);
    write_byte(8'hA5, acks[2]);
    write_byte(8'h5A, acks[3]);
    i2c_stop();
    tests_run++; if (acks !== 4'b0000)    begin fails++; $display("FAIL wr_acks got %b exp 0000", acks); end
    tests_run++; if (we_cnt !== 2)        begin fails++; $display("FAIL wr_we_count got %0d exp 2", we_cnt); end
    tests_run++; if (we_addr[0] !== 8'h10) begin fails++; $display("FAIL wr_addr0 got %h exp 10", we_addr[0]); end
    tests_run++; if (we_data[0] !== 8'hA5) begin fails++; $display("FAIL wr_data0 got %h exp a5", we_data[0]); end
    tests_run++; if (we_addr[1] !== 8'h11) begin fails++; $display("FAIL wr_addr1 got %h exp 11", we_addr[1]); end
    tests_run++; if (we_data[1] !== 8'h5A) begin fails++; $display("FAIL wr_data1 got %h exp 5a", we_data[1]); end
    tests_run++; if (bus.reg_addr !== 8'h12) begin fails++; $display("FAIL wr_final_ptr got %h exp 12", bus.reg_addr); end
    tests_run++; if (bus.busy !== 1'b0)   begin fails++; $display("FAIL wr_busy_after_stop got %b exp 0", bus.busy); end
  endtask

  task automatic test_read();
    logic [2:0] acks;
    logic [7:0] b0, b1;
    clear_mon();
    i2c_start();
    write_byte(8'h84, acks[0]);
    write_byte(8'h10, acks[1]);
    i2c_start();
    write_byte(8'h85, acks[2]);
    read_byte(1'b0, b0);
    read_byte(1'b1, b1);
    i2c_stop();
    tests_run++; if (acks !== 3'b000)   begin fails++; $display("FAIL rd_acks got %b exp 000", acks); end
    tests_run++; if (b0 !== 8'hEF)      begin fails++; $display("FAIL rd_byte0 got %h exp ef", b0); end
    tests_run++; if (b1 !== 8'hEE)      begin fails++; $display("FAIL rd_byte1 got %h exp ee", b1); end
    tests_run++; if (rd_cnt !== 2)      begin fails++; $display("FAIL rd_strobes got %0d exp 2", rd_cnt); end
    tests_run++; if (we_cnt !== 0)      begin fails++; $display("FAIL rd_we_count got %0d exp 0", we_cnt); end
    tests_run++; if (bus.reg_addr !== 8'h12) begin fails++; $display("FAIL rd_final_ptr got %h exp 12", bus.reg_addr); end
  endtask

  task automatic test_mismatch();
    logic [2:0] acks;
    clear_mon();
    i2c_start();
    write_byte(8'h86, acks[0]);
    write_byte(8'h10, acks[1]);
    write_byte(8'h33, acks[2]);
    i2c_stop();
    tests_run++; if (acks !== 3'b111)   begin fails++; $display("FAIL mm_acks got %b exp 111", acks); end
    tests_run++; if (oe_seen !== 1'b0)  begin fails++; $display("FAIL mm_sda_oe_seen got %b exp 0", oe_seen); end
    tests_run++; if (we_cnt !== 0)      begin fails++; $display("FAIL mm_we_count got %0d exp 0", we_cnt); end
    tests_run++; if (rd_cnt !== 0)      begin fails++; $display("FAIL mm_rd_count got %0d exp 0", rd_cnt); end
    tests_run++; if (busy_seen !== 1'b0) begin fails++; $display("FAIL mm_busy_seen got %b exp 0", busy_seen); end
  endtask

  task automatic test_abort();
    logic [1:0] acks;
    clear_mon();
    i2c_start();
    write_byte(8'h84, acks[0]);
    write_byte(8'h20, acks[1]);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    tests_run++; if (acks !== 2'b00)    begin fails++; $display("FAIL ab_acks got %b exp 00", acks); end
    tests_run++; if (we_cnt !== 0)      begin fails++; $display("FAIL ab_we_count got %0d exp 0", we_cnt); end
    tests_run++; if (bus.sda_oe !== 1'b0) begin fails++; $display("FAIL ab_sda_oe got %b exp 0", bus.sda_oe); end
    tests_run++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ab_busy got %b exp 0", bus.busy); end
    tests_run++; if (bus.reg_addr !== 8'h20) begin fails++; $display("FAIL ab_ptr got %h exp 20", bus.reg_addr); end
  endtask

  task automatic test_wrap();
    logic [3:0] acks;
    clear_mon();
    i2c_start();
    write_byte(8'h84, acks[0]);
    write_byte(8'hFF, acks[1]);
    write_byte(8'h01, acks[2]);
    write_byte(8'h02, acks[3]);
    i2c_stop();
    tests_run++; if (we_cnt !== 2)         begin fails++; $display("FAIL wrap_we_count got %0d exp 2", we_cnt); end
    tests_run++; if (we_addr[0] !== 8'hFF) begin fails++; $display("FAIL wrap_addr0 got %h exp ff", we_addr[0]); end
    tests_run++; if (we_data[0] !== 8'h01) begin fails++; $display("FAIL wrap_data0 got %h exp 01", we_data[0]); end
    tests_run++; if (we_addr[1] !== 8'h00) begin fails++; $display("FAIL wrap_addr1 got %h exp 00", we_addr[1]); end
    tests_run++; if (we_data[1] !== 8'h02) begin fails++; $display("FAIL wrap_data1 got %h exp 02", we_data[1]); end
    tests_run++; if (bus.reg_addr !== 8'h01) begin fails++; $display("FAIL wrap_final_ptr got %h exp 01", bus.reg_addr); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    a = 8'h84;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(a[i]);
    sda_m = 1'b1;
    for (int i = 0; i < 64 && bus.sda_oe !== 1'b1; i++) @(negedge clk);
    tests_run++; if (bus.sda_oe !== 1'b1) begin fails++; $display("FAIL rm_ack_driven got %b exp 1", bus.sda_oe); end
    @(negedge clk);
    reset_in = 1'b1;
    #1;
    tests_run++; if (bus.sda_oe !== 1'b0) begin fails++; $display("FAIL rm_sda_oe_async got %b exp 0", bus.sda_oe); end
    tests_run++; if (bus.busy !== 1'b0)   begin fails++; $display("FAIL rm_busy got %b exp 0", bus.busy); end
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
    scl_m = 1'b1; qwait(); qwait();
    tests_run++; if (bus.reg_addr !== 8'h00) begin fails++; $display("FAIL rm_ptr got %h exp 00", bus.reg_addr); end
  endtask

  task automatic test_glitch();
    logic [2:0] acks;
    logic [7:0] exp_data;
`ifdef I2C_TARGET_FILTER_EN
    exp_data = 8'h37;   // glitch rejected
`else
    exp_data = 8'h9B;   // glitch clocks in an extra '1': {1, 0011011}
`endif
    clear_mon();
    i2c_start();
    write_byte(8'h84, acks[0]);
    write_byte(8'h30, acks[1]);
    @(negedge clk); scl_m = 1'b1;
    @(negedge clk); scl_m = 1'b0;
    qwait();
    write_byte(8'h37, acks[2]);
    i2c_stop();
    tests_run++; if (acks[1:0] !== 2'b00)  begin fails++; $display("FAIL gl_acks got %b exp 00", acks[1:0]); end
    tests_run++; if (we_cnt !== 1)         begin fails++; $display("FAIL gl_we_count got %0d exp 1", we_cnt); end
    tests_run++; if (we_addr[0] !== 8'h30) begin fails++; $display("FAIL gl_addr got %h exp 30", we_addr[0]); end
    tests_run++; if (we_data[0] !== exp_data) begin fails++; $display("FAIL gl_data got %h exp %h", we_data[0], exp_data); end
  endtask

  initial begin
    repeat (4) @(negedge clk);
    reset_in = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_abort();
    test_wrap();
    test_reset_mid();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #2_000_000;
    $display("FAIL timeout tests_run=%0d", tests_run);
    $fatal(1, "timeout");
  end

endmodule
